// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with a TX FIFO.
// Firmware stores bytes to DATA; they go out on tx as 8N1, or 8E1 frames.
//
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit per frame.
// Ports:
//   clock, reset (async, active low)
//   store, load, address, store_data   CPU bus access
//   load_data                          read data, 0 when not selected
//   sel                                access hits DATA or STATUS
//   tx                                 serial output, idle high
// Registers: DATA at BASE_ADDR, STATUS at BASE_ADDR + XLEN/8.
//   STATUS: [0] full [1] empty [2] idle [3] ovf [11:8] count.
module uart_tx_mmio #(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  BASE_ADDR  = XLEN'(32'h20000010),
    parameter int               CLK_DIV    = 16,
    parameter int               FIFO_DEPTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            store,
    input  logic            load,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic            sel,
    output logic            tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLK_DIV);

    localparam logic [XLEN-1:0] DATA_ADDR = BASE_ADDR;
    localparam logic [XLEN-1:0] STAT_ADDR = BASE_ADDR + XLEN'(XLEN / 8);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PAR,
`endif
        S_STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;

    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bitcnt, bit_n;
    logic [7:0]    shreg, sh_n;
    logic          tx_n;

    logic hit_data, hit_stat, wr_data, wr_stat;
    logic full, empty, push, pop, tick, idle;
    logic ovf_set, ovf_clr;
    logic [XLEN-1:0] status;
    logic unused_bits;

    assign hit_data = (address == DATA_ADDR);
    assign hit_stat = (address == STAT_ADDR);
    assign sel      = (load | store) & (hit_data | hit_stat);
    assign wr_data  = store & hit_data;
    assign wr_stat  = store & hit_stat;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A push into a full FIFO is dropped even if a pop frees a slot now.
    assign push    = wr_data & ~full;
    assign ovf_set = wr_data & full;
    assign ovf_clr = wr_stat & store_data[3];
    assign idle    = (state == S_IDLE) & empty;

    assign unused_bits = ^store_data[XLEN-1:8];

    always_comb begin
        status         = '0;
        status[0]      = full;
        status[1]      = empty;
        status[2]      = idle;
        status[3]      = ovf;
        status[8 +: CW] = count;
    end

    assign load_data = (load & hit_stat) ? status : '0;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= store_data[7:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            // Set wins over a simultaneous clear.
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    assign tick = (baud == BAUD_LAST);

    always_comb begin
        state_n = state;
        bit_n   = bitcnt;
        sh_n    = shreg;
        pop     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    sh_n    = mem[rd_ptr];
                    state_n = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    bit_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = S_PAR;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PAR: begin
                if (tick) state_n = S_STOP;
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit when more is queued.
                if (tick) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        sh_n    = mem[rd_ptr];
                        state_n = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Leaving IDLE happens without a tick, so a state change restarts too.
        if (state_n == S_IDLE || tick || state_n != state)
            baud_n = '0;
        else
            baud_n = baud + BW'(1);

        tx_n = 1'b1;
        unique case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = sh_n[bit_n];
`ifdef UART_TX_PARITY_EN
            S_PAR:   tx_n = ^sh_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            baud   <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            tx     <= 1'b1;
        end else begin
            state  <= state_n;
            baud   <= baud_n;
            bitcnt <= bit_n;
            shreg  <= sh_n;
            tx     <= tx_n;
        end
    end

endmodule
